// File: rtl/eva_intr_pkg.sv
// Shared constants, mode encodings and helpers for the EVA interrupt collector.
package eva_intr_pkg;

    localparam int OVF_W = 16;

    typedef enum logic {
        EVA_INTR_LEVEL = 1'b0,
        EVA_INTR_EDGE  = 1'b1
    } intr_mode_e;

    function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
        return (&v) ? v : v + {{(OVF_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/eva_intr_fifo.sv
// Single-clock show-ahead FIFO; pointers carry one extra wrap bit for full/empty.
module eva_intr_fifo
    import eva_intr_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic          wr_en, rd_en;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign level = wptr_q - rptr_q;
    // Zero the head when empty so the record port reads 0 out of reset.
    assign rdata = empty ? '0 : mem_q[rptr_q[AW-1:0]];

    // A push on full is still taken when the head leaves in the same cycle.
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_en) begin
            mem_d[wptr_q[AW-1:0]] = wdata;
            wptr_d = wptr_q + PTR_ONE;
        end
        if (rd_en) begin
            rptr_d = rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/eva_intr_collect.sv
// Interrupt collector: edge/level qualify, sticky pending, buffered {vec, ts} events.
// Build option EVA_INTR_TSTAMP_EN adds the timestamp counter and ts field.
module eva_intr_collect
    import eva_intr_pkg::*;
#(
    parameter int N_INTR = 32,
    parameter int DEPTH  = 8,
    parameter int TS_W   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_INTR-1:0]       interrupt,
    input  logic [N_INTR-1:0]       cfg_mode,
    input  logic [N_INTR-1:0]       cfg_mask,
    input  logic [N_INTR-1:0]       clr,
    output logic [N_INTR-1:0]       pend,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [N_INTR-1:0]       evt_vec,
    output logic [TS_W-1:0]         evt_ts,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [OVF_W-1:0]        ovf_cnt
);
`ifdef EVA_INTR_TSTAMP_EN
    typedef struct packed {
        logic [N_INTR-1:0] vec;
        logic [TS_W-1:0]   ts;
    } evt_rec_t;
`else
    typedef struct packed {
        logic [N_INTR-1:0] vec;
    } evt_rec_t;
`endif
    localparam int REC_W = $bits(evt_rec_t);

    logic [N_INTR-1:0] intr_ff_q, intr_ff_d;
    logic [N_INTR-1:0] pend_q, pend_d;
    logic [N_INTR-1:0] rise, hit;
    logic [OVF_W-1:0]  ovf_cnt_q, ovf_cnt_d;
    evt_rec_t          push_rec, head_rec;
    logic              push, pop, drop;
    logic              fifo_full, fifo_empty;

    assign rise = interrupt & ~intr_ff_q;

    // Level channels fire only while not pending, so each assertion yields one hit.
    for (genvar i = 0; i < N_INTR; i++) begin : g_lane
        assign hit[i] = cfg_mask[i] &
                        ((cfg_mode[i] == EVA_INTR_EDGE) ? rise[i] : (interrupt[i] & ~pend_q[i]));
    end

    assign push      = (|hit) & ~rst;
    assign pop       = evt_valid & evt_ready;
    assign drop      = push & fifo_full & ~pop;
    assign evt_valid = ~fifo_empty;
    assign push_rec.vec = hit;
    assign evt_vec   = head_rec.vec;
    assign pend      = pend_q;
    assign ovf_cnt   = ovf_cnt_q;

`ifdef EVA_INTR_TSTAMP_EN
    logic [TS_W-1:0] ts_cnt_q, ts_cnt_d;

    always_comb begin
        ts_cnt_d = ts_cnt_q + {{(TS_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) ts_cnt_q <= '0;
        else     ts_cnt_q <= ts_cnt_d;
    end

    assign push_rec.ts = ts_cnt_q;
    assign evt_ts      = head_rec.ts;
`else
    assign evt_ts = {TS_W{1'b0}};
`endif

    always_comb begin
        intr_ff_d = interrupt;
        pend_d    = (pend_q & ~clr) | hit;
        ovf_cnt_d = drop ? sat_inc(ovf_cnt_q) : ovf_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            intr_ff_q <= '0;
            pend_q    <= '0;
            ovf_cnt_q <= '0;
        end else begin
            intr_ff_q <= intr_ff_d;
            pend_q    <= pend_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    eva_intr_fifo #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (push_rec),
        .rdata (head_rec),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

endmodule

// File: tb/tb_eva_intr_collect.sv
// Directed bench for eva_intr_collect: vector table plus multi-cycle corner sequences.
module tb_eva_intr_collect;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] interrupt, cfg_mode, cfg_mask, clr;
    logic [31:0] pend, evt_vec, evt_ts;
    logic        evt_valid, evt_ready;
    logic [3:0]  fifo_level;
    logic [15:0] ovf_cnt;

    int errors = 0;
    int checks = 0;
    logic [31:0] m_ts;

    eva_intr_collect #(.N_INTR(32), .DEPTH(8), .TS_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .interrupt  (interrupt),
        .cfg_mode   (cfg_mode),
        .cfg_mask   (cfg_mask),
        .clr        (clr),
        .pend       (pend),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_vec    (evt_vec),
        .evt_ts     (evt_ts),
        .fifo_level (fifo_level),
        .ovf_cnt    (ovf_cnt)
    );

    always #5 clk = ~clk;

    // Reference cycle count: value of the timestamp counter in the current cycle.
    always @(posedge clk) m_ts <= rst ? 32'd0 : m_ts + 32'd1;

    typedef struct {
        logic [31:0] intr;
        logic [31:0] mask;
        logic [31:0] clr;
        logic        rdy;
        logic [31:0] pend;
        logic        vld;
        logic [31:0] vec;
        logic [3:0]  lvl;
    } vec_t;

    vec_t tbl[25];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ets(input logic [31:0] t);
`ifdef EVA_INTR_TSTAMP_EN
        return t;
`else
        return 32'd0 & t;
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        interrupt = '0;
        clr = '0;
        evt_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] t0;
        logic [31:0] exp_v;
        int          cnt;
        localparam logic [31:0] M = 32'h8000_0019;
        localparam logic [31:0] K = 32'h8000_0029;

        tbl[0]  = '{32'h0,         K,          32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         4'd0};
        tbl[1]  = '{32'h8,         K,          32'h0,         1'b0, 32'h8,         1'b1, 32'h8,         4'd1};
        tbl[2]  = '{32'h8,         K,          32'h0,         1'b0, 32'h8,         1'b1, 32'h8,         4'd1};
        tbl[3]  = '{32'h8,         K,          32'h0,         1'b0, 32'h8,         1'b1, 32'h8,         4'd1};
        tbl[4]  = '{32'h8,         K,          32'h0,         1'b0, 32'h8,         1'b1, 32'h8,         4'd1};
        tbl[5]  = '{32'h0,         K,          32'h0,         1'b0, 32'h8,         1'b1, 32'h8,         4'd1};
        tbl[6]  = '{32'h8000_0001, K,          32'h0,         1'b0, 32'h8000_0009, 1'b1, 32'h8,         4'd2};
        tbl[7]  = '{32'h0,         K,          32'h0,         1'b1, 32'h8000_0009, 1'b1, 32'h8000_0001, 4'd1};
        tbl[8]  = '{32'h0,         K,          32'h0,         1'b1, 32'h8000_0009, 1'b0, 32'h0,         4'd0};
        tbl[9]  = '{32'h0,         K,          32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0, 32'h0,         4'd0};
        tbl[10] = '{32'h20,        K,          32'h0,         1'b0, 32'h20,        1'b1, 32'h20,        4'd1};
        tbl[11] = '{32'h20,        K,          32'h0,         1'b0, 32'h20,        1'b1, 32'h20,        4'd1};
        tbl[12] = '{32'h20,        K,          32'h20,        1'b0, 32'h0,         1'b1, 32'h20,        4'd1};
        tbl[13] = '{32'h20,        K,          32'h0,         1'b0, 32'h20,        1'b1, 32'h20,        4'd2};
        tbl[14] = '{32'h20,        K,          32'h0,         1'b1, 32'h20,        1'b1, 32'h20,        4'd1};
        tbl[15] = '{32'h60,        K,          32'h0,         1'b0, 32'h20,        1'b1, 32'h20,        4'd1};
        tbl[16] = '{32'h70,        K,          32'h0,         1'b0, 32'h20,        1'b1, 32'h20,        4'd1};
        tbl[17] = '{32'h70,        K | 32'h10, 32'h0,         1'b0, 32'h20,        1'b1, 32'h20,        4'd1};
        tbl[18] = '{32'h70,        K | 32'h50, 32'h0,         1'b0, 32'h60,        1'b1, 32'h20,        4'd2};
        tbl[19] = '{32'h70,        K | 32'h50, 32'h0,         1'b1, 32'h60,        1'b1, 32'h40,        4'd1};
        tbl[20] = '{32'h70,        K | 32'h50, 32'h0,         1'b1, 32'h60,        1'b0, 32'h0,         4'd0};
        tbl[21] = '{32'h0,         K,          32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0, 32'h0,         4'd0};
        tbl[22] = '{32'h8,         K,          32'h0,         1'b0, 32'h8,         1'b1, 32'h8,         4'd1};
        tbl[23] = '{32'h0,         K,          32'h0,         1'b1, 32'h8,         1'b0, 32'h0,         4'd0};
        tbl[24] = '{32'h8,         K,          32'h8,         1'b0, 32'h8,         1'b1, 32'h8,         4'd1};

        cfg_mode = '0;
        cfg_mask = '0;
        interrupt = '0;
        clr = '0;
        evt_ready = 1'b0;

        // Reset state
        rst = 1'b1;
        step();
        step();
        chk("rst_pend",  pend,       0);
        chk("rst_valid", evt_valid,  0);
        chk("rst_vec",   evt_vec,    0);
        chk("rst_ts",    evt_ts,     0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf",   ovf_cnt,    0);

        // Vector table
        do_reset();
        cfg_mode = M;
        for (int i = 0; i < 25; i++) begin
            interrupt = tbl[i].intr;
            cfg_mask  = tbl[i].mask;
            clr       = tbl[i].clr;
            evt_ready = tbl[i].rdy;
            step();
            chk($sformatf("tbl%0d_pend", i),  pend,       tbl[i].pend);
            chk($sformatf("tbl%0d_valid", i), evt_valid,  tbl[i].vld);
            chk($sformatf("tbl%0d_vec", i),   evt_vec,    tbl[i].vec);
            chk($sformatf("tbl%0d_level", i), fifo_level, tbl[i].lvl);
        end
        clr = '0;
        evt_ready = 1'b0;

        // Edge channel 3 held 4 cycles from ts 10: one record stamped 10
        do_reset();
        cfg_mode = 32'h8;
        cfg_mask = 32'h8;
        for (int j = 0; j < 10; j++) step();
        t0 = m_ts;
        interrupt = 32'h8;
        for (int j = 0; j < 4; j++) step();
        interrupt = '0;
        step();
        chk("edge_level", fifo_level, 1);
        chk("edge_vec",   evt_vec,    32'h8);
        chk("edge_ts",    evt_ts,     ets(t0));
        chk("edge_ts10",  evt_ts,     ets(32'd10));
        chk("edge_pend",  pend,       32'h8);

        // Level channel 5 held, clr twice 5 cycles apart: three records
        do_reset();
        cfg_mode = 32'h0;
        cfg_mask = 32'h20;
        evt_ready = 1'b1;
        interrupt = 32'h20;
        cnt = 0;
        for (int j = 0; j < 15; j++) begin
            clr = (j == 2 || j == 7) ? 32'h20 : 32'h0;
            step();
            if (evt_valid && evt_vec == 32'h20) cnt++;
            if (j == 0 || j == 3 || j == 8) chk($sformatf("lvl_fire%0d", j), evt_valid, 1);
        end
        clr = '0;
        chk("lvl_count", cnt, 3);

        // Overflow: ten edge events into an 8-deep FIFO
        do_reset();
        cfg_mode = 32'hFFFF_FFFF;
        cfg_mask = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            interrupt = 32'd1 << i;
            step();
            interrupt = '0;
            step();
        end
        chk("ovf_level", fifo_level, 8);
        chk("ovf_cnt",   ovf_cnt,    2);
        chk("ovf_head",  evt_vec,    32'h1);

        // Full FIFO, push and pop together
        interrupt = 32'd1 << 20;
        evt_ready = 1'b1;
        step();
        interrupt = '0;
        evt_ready = 1'b0;
        chk("fullpp_ovf",   ovf_cnt,    2);
        chk("fullpp_level", fifo_level, 8);
        chk("fullpp_head",  evt_vec,    32'h2);

        evt_ready = 1'b1;
        for (int i = 1; i < 9; i++) begin
            exp_v = (i == 8) ? (32'd1 << 20) : (32'd1 << i);
            chk($sformatf("drain%0d_valid", i), evt_valid, 1);
            chk($sformatf("drain%0d_vec", i),   evt_vec,   exp_v);
            step();
        end
        evt_ready = 1'b0;
        chk("drain_empty", evt_valid,  0);
        chk("drain_level", fifo_level, 0);

        // Reset with 4 queued entries and line 1 still high
        for (int i = 0; i < 4; i++) begin
            interrupt = 32'd1 << i;
            step();
            interrupt = '0;
            step();
        end
        chk("preq_level", fifo_level, 4);
        interrupt = 32'h2;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("mrst_pend",  pend,       0);
        chk("mrst_ovf",   ovf_cnt,    0);
        chk("mrst_level", fifo_level, 0);
        chk("mrst_valid", evt_valid,  0);
        step();
        chk("mrst_re_pend",  pend,       32'h2);
        chk("mrst_re_valid", evt_valid,  1);
        chk("mrst_re_vec",   evt_vec,    32'h2);
        chk("mrst_re_ts",    evt_ts,     ets(32'd0));
        chk("mrst_re_level", fifo_level, 1);
        interrupt = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
